// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch front end.
package fetch_pkg;

  localparam int FETCH_PC_W     = 8;
  localparam int FETCH_INSTR_W  = 16;
  localparam int FETCH_PC_INC   = 4;
  localparam int FETCH_DEPTH    = 4;
  localparam int FETCH_RESET_PC = 0;

  // Queue entry layout at the default widths. The parametrised RTL builds
  // an identically shaped local struct so that {pc, instr} ordering stays
  // the same at any width.
  typedef struct packed {
    logic [FETCH_PC_W-1:0]    pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Occupancy counter width for a power-of-two queue: needs to hold DEPTH itself.
  function automatic int fetch_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch front-end bus: instruction memory port, redirect input and decode handshake.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int PC_W    = FETCH_PC_W,
  parameter int INSTR_W = FETCH_INSTR_W
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_en;
  logic [PC_W-1:0]    redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [PC_W-1:0]    instr_pc;

  // Fetch unit side.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  redirect_en,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr_data,
    output instr_pc
  );

  // Memory / decode / control side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output redirect_en,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr_data,
    input  instr_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular fetch buffer: DEPTH entries, naturally wrapping pointers, flush to empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int WIDTH = FETCH_PC_W + FETCH_INSTR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fetch_cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  // Pointer and occupancy update; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_W'(1);
      if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; cleared on reset so an empty queue presents zeros at the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !i_flush) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, one-deep in-flight tracking, credit-based issue,
// redirect masking, and a buffer queue towards decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W     = FETCH_PC_W,
  parameter int INSTR_W  = FETCH_INSTR_W,
  parameter int PC_INC   = FETCH_PC_INC,
  parameter int DEPTH    = FETCH_DEPTH,
  parameter int RESET_PC = FETCH_RESET_PC
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);

  localparam int CNT_W = fetch_cnt_w(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0]  r_pc;
  logic             r_inflight;
  logic [PC_W-1:0]  r_inflight_pc;

  logic             w_redirect;
  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [PC_W-1:0]  w_addr;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occ;
  entry_t           w_head;
  entry_t           w_push_entry;

  // Redirect qualification: a redirect hides the head, blocks the pop and drops the returning word.
  always_comb begin
    w_redirect   = bus.redirect_en & ~reset;
    w_valid      = (w_count != '0) & ~w_redirect;
    w_pop        = w_valid & bus.instr_ready;
    w_push       = r_inflight & ~w_redirect;
    w_push_entry = '{pc: r_inflight_pc, instr: bus.imem_rdata};
  end

  // Issue only when the buffered plus in-flight words, after this cycle's pop, leave room for one more.
  always_comb begin
    w_occ   = {1'b0, w_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
    w_issue = ~reset & (w_redirect | (w_occ < (CNT_W+1)'(DEPTH)));
    w_addr  = w_redirect ? bus.redirect_pc : r_pc;
  end

  // Sequential PC advance and in-flight bookkeeping; PC wraps modulo 2^PC_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= PC_W'(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= PC_W'(RESET_PC);
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= w_addr + PC_W'(PC_INC);
        r_inflight_pc <= w_addr;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + INSTR_W)
  ) u_queue (
    .clk         (clk),
    .rst         (reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (w_redirect),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign bus.imem_req    = w_issue;
  assign bus.imem_addr   = w_addr;
  assign bus.instr_valid = w_valid;
  assign bus.instr_data  = w_head.instr;
  assign bus.instr_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: DEPTH=4 instance for directed timing checks, DEPTH=2
// instance for randomised back-pressure; stream-level scoreboard on both.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [7:0] RST_PC = 8'h00;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  fetch_if #(.PC_W(8), .INSTR_W(16)) bus0 ();
  fetch_if #(.PC_W(8), .INSTR_W(16)) bus1 ();

  fetch_unit #(.PC_W(8), .INSTR_W(16), .PC_INC(4), .DEPTH(4), .RESET_PC(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  fetch_unit #(.PC_W(8), .INSTR_W(16), .PC_INC(4), .DEPTH(2), .RESET_PC(0)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  logic       ready [2];
  logic       redir [2];
  logic [7:0] rpc   [2];
  logic       req   [2];
  logic       valid [2];
  logic [7:0] addr  [2];
  logic [7:0] ipc   [2];
  logic [15:0] idata [2];

  assign bus0.instr_ready = ready[0];
  assign bus0.redirect_en = redir[0];
  assign bus0.redirect_pc = rpc[0];
  assign bus1.instr_ready = ready[1];
  assign bus1.redirect_en = redir[1];
  assign bus1.redirect_pc = rpc[1];

  assign req[0]   = bus0.imem_req;
  assign valid[0] = bus0.instr_valid;
  assign addr[0]  = bus0.imem_addr;
  assign ipc[0]   = bus0.instr_pc;
  assign idata[0] = bus0.instr_data;
  assign req[1]   = bus1.imem_req;
  assign valid[1] = bus1.instr_valid;
  assign addr[1]  = bus1.imem_addr;
  assign ipc[1]   = bus1.instr_pc;
  assign idata[1] = bus1.instr_data;

  function automatic logic [15:0] word_of(input logic [7:0] pc);
    return {pc ^ 8'h5A, pc};
  endfunction

  // Synchronous instruction memory: word for the requested address the cycle after.
  always @(posedge clk) begin
    bus0.imem_rdata <= bus0.imem_req ? word_of(bus0.imem_addr) : 16'hDEAD;
    bus1.imem_rdata <= bus1.imem_req ? word_of(bus1.imem_addr) : 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Stream model: fetches go out in PC order from the last redirect target;
  // decode sees every fetched PC exactly once, in order, until a redirect
  // restarts both streams. outst = issued-but-not-yet-accepted words.
  int         outst    [2];
  int         accepted [2];
  logic [7:0] exp_f    [2];
  logic [7:0] exp_d    [2];

  task automatic score(input int g);
    int dep;
    int acc;
    fetch_entry_t e;
    dep = (g == 0) ? 4 : 2;
    if (reset) begin
      chk("reset_req", req[g], 1'b0);
      chk("reset_valid", valid[g], 1'b0);
      outst[g] = 0;
      exp_f[g] = RST_PC;
      exp_d[g] = RST_PC;
      return;
    end
    acc = (valid[g] && ready[g]) ? 1 : 0;
    chk("occupancy_le_depth", outst[g] <= dep, 1'b1);
    if (redir[g]) begin
      chk("redirect_valid", valid[g], 1'b0);
      chk("redirect_req", req[g], 1'b1);
      chk("redirect_addr", addr[g], rpc[g]);
      exp_f[g] = rpc[g] + 8'd4;
      exp_d[g] = rpc[g];
      outst[g] = 1;
    end else begin
      chk("req_when_room", req[g], (outst[g] - acc) < dep);
      if (req[g]) begin
        chk("fetch_addr", addr[g], exp_f[g]);
        exp_f[g] = exp_f[g] + 8'd4;
      end
      if (acc == 1) begin
        e.pc    = exp_d[g];
        e.instr = word_of(exp_d[g]);
        chk("decode_entry", {ipc[g], idata[g]}, e);
        exp_d[g] = exp_d[g] + 8'd4;
        accepted[g]++;
      end
      outst[g] = outst[g] + (req[g] ? 1 : 0) - acc;
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) score(g);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int acc_before;

  initial begin
    reset = 1'b1;
    ready = '{1'b1, 1'b1};
    redir = '{1'b0, 1'b0};
    rpc   = '{8'h00, 8'h00};
    outst = '{0, 0};
    accepted = '{0, 0};
    exp_f = '{8'h00, 8'h00};
    exp_d = '{8'h00, 8'h00};

    repeat (3) @(posedge clk);
    smp();
    chk("rst_imem_req", req[0], 1'b0);
    chk("rst_imem_addr", addr[0], 8'h00);
    chk("rst_instr_valid", valid[0], 1'b0);
    chk("rst_instr_data", idata[0], 16'h0000);
    chk("rst_instr_pc", ipc[0], 8'h00);

    // Release; this cycle is C0.
    cyc(); reset = 1'b0;
    smp();
    chk("c0_req", req[0], 1'b1);
    chk("c0_addr", addr[0], 8'h00);
    chk("c0_valid", valid[0], 1'b0);
    cyc(); smp();
    chk("c1_addr", addr[0], 8'h04);
    chk("c1_valid", valid[0], 1'b0);
    cyc(); smp();
    chk("c2_valid", valid[0], 1'b1);
    chk("c2_pc", ipc[0], 8'h00);
    chk("c2_data", idata[0], 16'h5A00);
    cyc(); smp();
    chk("c3_valid", valid[0], 1'b1);
    chk("c3_pc", ipc[0], 8'h04);

    // Back-pressure for 10 cycles (C4..C13).
    cyc(); ready[0] = 1'b0;
    smp();
    chk("bp_head", ipc[0], 8'h08);
    repeat (9) begin cyc(); smp(); end
    chk("bp_req_stopped", req[0], 1'b0);
    chk("bp_valid", valid[0], 1'b1);
    chk("bp_head_held", ipc[0], 8'h08);

    // Release: 08,0C,10,14 buffered, then 18 with no gap.
    cyc(); ready[0] = 1'b1;
    smp();
    chk("drain_req", req[0], 1'b1);
    chk("drain_addr", addr[0], 8'h18);
    chk("drain_pc0", ipc[0], 8'h08);
    for (int k = 1; k <= 4; k++) begin
      cyc(); smp();
      chk("drain_valid", valid[0], 1'b1);
      chk("drain_pc", ipc[0], 8'(8'h08 + 4 * k));
    end

    // Redirect to 0x40 with 3 queued and one in flight.
    cyc(); redir[0] = 1'b1; rpc[0] = 8'h40;
    smp();
    chk("rd40_valid_t", valid[0], 1'b0);
    chk("rd40_addr", addr[0], 8'h40);
    cyc(); redir[0] = 1'b0;
    smp();
    chk("rd40_valid_t1", valid[0], 1'b0);
    chk("rd40_next_addr", addr[0], 8'h44);
    cyc(); smp();
    chk("rd40_pc", ipc[0], 8'h40);
    chk("rd40_data", idata[0], 16'h1A40);
    cyc(); smp();
    chk("rd44_pc", ipc[0], 8'h44);

    // Redirect to 0xFC: wrap to 0x00.
    cyc(); redir[0] = 1'b1; rpc[0] = 8'hFC;
    smp();
    chk("rdfc_valid_t", valid[0], 1'b0);
    cyc(); redir[0] = 1'b0;
    smp();
    chk("rdfc_valid_t1", valid[0], 1'b0);
    chk("wrap_addr", addr[0], 8'h00);
    cyc(); smp();
    chk("wrap_pc_fc", ipc[0], 8'hFC);
    cyc(); smp();
    chk("wrap_pc_00", ipc[0], 8'h00);
    cyc(); smp();
    chk("wrap_pc_04", ipc[0], 8'h04);
    chk("pre_reset_valid", valid[0], 1'b1);

    // Asynchronous reset mid-cycle, no clock edge in between.
    #1 reset = 1'b1;
    #1;
    chk("async_valid0", valid[0], 1'b0);
    chk("async_req0", req[0], 1'b0);
    chk("async_valid1", valid[1], 1'b0);
    chk("async_pc0", ipc[0], 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    smp();
    chk("restart_req", req[0], 1'b1);
    chk("restart_addr", addr[0], 8'h00);
    chk("restart_valid", valid[0], 1'b0);
    cyc(); smp();
    chk("restart_addr1", addr[0], 8'h04);
    cyc(); smp();
    chk("restart_pc", ipc[0], 8'h00);

    // Randomised ready on both, occasional redirects on the DEPTH=4 instance.
    acc_before = accepted[1];
    repeat (1000) begin
      cyc();
      ready[0] = 1'($urandom_range(0, 1));
      ready[1] = 1'($urandom_range(0, 1));
      redir[0] = ($urandom_range(0, 15) == 0);
      rpc[0]   = 8'($urandom_range(0, 63) * 4);
    end
    cyc();
    redir[0] = 1'b0;
    ready = '{1'b1, 1'b1};
    repeat (5) begin cyc(); end
    smp();
    chk("random_progress", (accepted[1] - acc_before) >= 300, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end. It keeps the program counter and issues one sequential fetch per cycle to a synchronous instruction memory. Returned words are buffered with their PC in a small queue and handed to decode over a valid/ready handshake. Control-flow redirects flush the buffer and kill the in-flight fetch. It replaces the fixed 8-bit/16-bit fetch stage and adds decode back-pressure, buffering and configurable widths.

## Interface
Parameters:
- PC_W, 8, program counter / fetch address width
- INSTR_W, 16, instruction word width
- PC_INC, 4, sequential PC increment
- DEPTH, 4, fetch queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- imem_req  out  1  fetch request this cycle
- imem_addr  out  PC_W  fetch address, meaningful when imem_req=1
- imem_rdata  in  INSTR_W  read data, valid the cycle after a request
- redirect_en  in  1  take redirect_pc this cycle (branch/jump/exception)
- redirect_pc  in  PC_W  redirect target
- instr_valid  out  1  queue head holds an instruction
- instr_ready  in  1  decode accepts head this cycle
- instr_data  out  INSTR_W  head instruction
- instr_pc  out  PC_W  PC of head instruction

## Operation
- State: pc register, inflight flag plus inflight_pc, fetch queue of {pc, instr} entries with count.
- Pop: pop = instr_valid & instr_ready. instr_valid = (count≠0) & ~redirect_en.
- Issue: imem_req = ~reset & (redirect_en | (count + inflight − pop < DEPTH)).
- Fetch address: imem_addr = redirect_en ? redirect_pc : pc.
- On issue, pc ← imem_addr + PC_INC, modulo 2^PC_W. 0xFC + 4 wraps to 0x00 at PC_W=8.
- Without issue, pc holds.
- Response: when inflight=1, imem_rdata and inflight_pc are pushed to the queue tail. Credit accounting guarantees the queue is never full at push.
- Redirect cycle:
  - queue count ← 0;
  - the response arriving this cycle is discarded (no push);
  - no pop completes;
  - a new fetch at redirect_pc is issued;
  - inflight ← 1 with inflight_pc = redirect_pc.
- Simultaneous push and pop: count unchanged, order preserved.
- A push into an empty queue is not bypassed to the output.
- reset beats redirect_en.

## Timing
- Reset values:
  - imem_req=0 while reset is asserted; imem_addr=RESET_PC.
  - instr_valid=0; instr_data=0; instr_pc=0 (queue storage cleared).
  - pc=RESET_PC; inflight=0; count=0.
- First cycle after reset release (C0): imem_req=1, imem_addr=RESET_PC.
- Fetch-to-decode latency is 2 cycles: request in cycle t, rdata in t+1, instr_valid with that word in t+2.
- Throughput is 1 instruction/cycle in steady state with instr_ready held high, for any DEPTH≥2.
- Back-pressure: with instr_ready=0, issue stops once count+inflight=DEPTH. The queue then holds exactly DEPTH entries and no fetch is lost.
- Redirect asserted in cycle t: the target word is presented in t+2. instr_valid is 0 in t and t+1.
- Reset asserted mid-operation drops queue contents and any in-flight fetch immediately (asynchronously).

## Structure
- Shared package fetch_pkg:
  - typedef fetch_entry_t {pc, instr};
  - default constants for PC_W, INSTR_W, PC_INC, RESET_PC.
- Sub-module fetch_queue: circular buffer, DEPTH entries.
  - Read/write pointers of log2(DEPTH) bits wrap naturally.
  - Count of log2(DEPTH)+1 bits.
  - Ports: push, pop, flush, head, count.
  - Asynchronous reset clears pointers, count and storage.
- fetch_unit holds pc, inflight/inflight_pc, credit and issue logic, and the redirect masking.

## Test plan
- Reset release, instr_ready=1, memory returns addr-derived words:
  - imem_addr runs 0x00, 0x04, 0x08…;
  - instr_valid first high 2 cycles after release with instr_pc=0x00, then one instruction per cycle, PCs in order.
- Hold instr_ready=0 for 10 cycles (DEPTH=4):
  - exactly 4 entries buffered; imem_req low afterwards;
  - on release, PCs 0x00–0x0C drain in order, then 0x10 follows with no gap or duplicate.
- redirect_en with redirect_pc=0x40 while the queue holds 3 entries and a fetch is in flight:
  - instr_valid=0 for 2 cycles;
  - next output instr_pc=0x40, then 0x44; no stale PCs appear.
- Redirect to 0xFC at PC_W=8: outputs 0xFC, 0x00, 0x04 (wrap).
- Assert reset mid-stream with queue non-empty:
  - instr_valid and imem_req drop without waiting for a clock edge;
  - after release, fetch restarts at RESET_PC.
- Randomised instr_ready with DEPTH=2 over 1000 cycles: scoreboard sees every PC exactly once, in order, and the queue never overflows.
